// File: rtl/exhaustive_bist_ctrl.sv
// Exhaustive-pattern BIST controller: counts through every CUT input
// vector, compacts responses into a MISR and compares against a golden value.
module exhaustive_bist_ctrl #(
    parameter int                N_IN      = 15,
    parameter int                N_OUT     = 2,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED = '0,
    parameter int                SETTLE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [MISR_W-1:0] golden_sig,
    output logic [N_IN-1:0]   cut_in,
    input  logic [N_OUT-1:0]  cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SET_MAX = 4'(SETTLE);

    state_t            state;
    state_t            state_nx;
    logic [N_IN-1:0]   pat;
    logic [3:0]        set;
    logic [MISR_W-1:0] misr;
    logic [MISR_W-1:0] misr_next;
    logic [MISR_W-1:0] d;
    logic [MISR_W-1:0] fb;
    logic              settled;
    logic              last;
    logic              init;
    logic              clear;
    logic              capture;
    logic              step;

    assign settled = (set >= SET_MAX);
    assign last    = &pat;

    assign d         = MISR_W'(cut_out);
    assign fb        = misr[MISR_W-1] ? MISR_POLY : '0;
    assign misr_next = {misr[MISR_W-2:0], 1'b0} ^ fb ^ d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start && !abort) state_nx = RUN;
            RUN: begin
                if (abort)                state_nx = IDLE;
                else if (settled && last) state_nx = DONE;
            end
            DONE: begin
                if (abort)      state_nx = IDLE;
                else if (start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == RUN);
        done    = (state == DONE);
        init    = (state != RUN) && start && !abort;
        clear   = (state != IDLE) && abort;
        capture = (state == RUN) && !abort && settled;
        step    = (state == RUN) && !abort && !settled;
    end

    // The final capture leaves pat at all-ones so DONE holds the last vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat  <= '0;
            set  <= '0;
            misr <= MISR_SEED;
        end else if (init || clear) begin
            pat  <= '0;
            set  <= '0;
            misr <= MISR_SEED;
        end else if (capture) begin
            misr <= misr_next;
            if (!last) begin
                pat <= pat + N_IN'(1);
                set <= '0;
            end
        end else if (step) begin
            set <= set + 4'd1;
        end
    end

    assign cut_in    = pat;
    assign signature = misr;
    assign pass      = done && (misr == golden_sig);

endmodule

// File: tb/tb_exhaustive_bist_ctrl.sv
// Bench for exhaustive_bist_ctrl: a small reference instance and a
// random-truth-table instance, both checked against a behavioural model.
module tb_exhaustive_bist_ctrl;

    localparam int         SET_A  = 0;
    localparam int         SET_B  = 2;
    localparam int         NPAT_A = 4;
    localparam int         NPAT_B = 32;
    localparam logic [3:0] SEED_A = 4'h0;
    localparam logic [7:0] SEED_B = 8'h5A;
    localparam logic [7:0] POLY_B = 8'h1D;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_start, a_abort, a_busy, a_done, a_pass;
    logic [3:0] a_golden, a_sig;
    logic [1:0] a_cut_in;
    logic [0:0] a_cut_out;
    logic       a_mode;

    logic       b_start, b_abort, b_busy, b_done, b_pass;
    logic [7:0] b_golden, b_sig;
    logic [4:0] b_cut_in;
    logic [2:0] b_cut_out;
    logic [2:0] tbl [32];

    int          sel;
    logic [31:0] cur_cut, cur_sig;
    logic        cur_busy, cur_done;

    int ntot  = 0;
    int npass = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    exhaustive_bist_ctrl #(
        .N_IN(2), .N_OUT(1), .MISR_W(4),
        .MISR_POLY(4'h3), .MISR_SEED(SEED_A), .SETTLE(SET_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .golden_sig(a_golden), .cut_in(a_cut_in), .cut_out(a_cut_out),
        .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig)
    );

    exhaustive_bist_ctrl #(
        .N_IN(5), .N_OUT(3), .MISR_W(8),
        .MISR_POLY(POLY_B), .MISR_SEED(SEED_B), .SETTLE(SET_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .golden_sig(b_golden), .cut_in(b_cut_in), .cut_out(b_cut_out),
        .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig)
    );

    assign a_cut_out = a_mode ? 1'(^a_cut_in) : 1'(&a_cut_in);
    assign b_cut_out = tbl[b_cut_in];

    always_comb begin
        cur_cut  = (sel != 0) ? 32'(b_cut_in) : 32'(a_cut_in);
        cur_sig  = (sel != 0) ? 32'(b_sig) : 32'(a_sig);
        cur_busy = (sel != 0) ? b_busy : a_busy;
        cur_done = (sel != 0) ? b_done : a_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which != 0) b_start = v;
        else            a_start = v;
    endtask

    task automatic set_abort(input int which, input logic v);
        if (which != 0) b_abort = v;
        else            a_abort = v;
    endtask

    // Signature from the MISR rule applied to the CUT truth table in count order.
    function automatic logic [31:0] ref_sig(input int which);
        int          w, n;
        logic [31:0] poly, m, dv, mask;
        logic        top;
        if (which == 0) begin
            w = 4; n = NPAT_A; poly = 32'h3; m = 32'(SEED_A);
        end else begin
            w = 8; n = NPAT_B; poly = 32'(POLY_B); m = 32'(SEED_B);
        end
        mask = (32'd1 << w) - 32'd1;
        for (int p = 0; p < n; p++) begin
            if (which == 0)
                dv = a_mode ? 32'($countones(p) % 2) : 32'(p == 3);
            else
                dv = 32'(tbl[p]);
            top = m[w-1];
            m = ((m << 1) & mask) ^ (top ? poly : 32'd0) ^ dv;
        end
        return m;
    endfunction

    task automatic run(input int which, input bit poke, input string tag);
        int hold, total;
        hold  = (which != 0) ? SET_B + 1 : SET_A + 1;
        total = ((which != 0) ? NPAT_B : NPAT_A) * hold;
        sel = which;
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        for (int k = 0; k < total; k++) begin
            chk({tag, "_cut_in"}, cur_cut, 32'(k / hold));
            chk({tag, "_busy"}, 32'(cur_busy), 32'd1);
            set_start(which, poke && (k == 3));
            @(negedge clk);
        end
        set_start(which, 1'b0);
        chk({tag, "_done"}, 32'(cur_done), 32'd1);
        chk({tag, "_busy_end"}, 32'(cur_busy), 32'd0);
        chk({tag, "_sig"}, cur_sig, ref_sig(which));
    endtask

    task automatic abort_at2(input int which, input string tag);
        int hold;
        hold = (which != 0) ? SET_B + 1 : SET_A + 1;
        sel = which;
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        repeat (2 * hold) @(negedge clk);
        chk({tag, "_at2"}, cur_cut, 32'd2);
        set_abort(which, 1'b1);
        @(negedge clk);
        set_abort(which, 1'b0);
        chk({tag, "_busy"}, 32'(cur_busy), 32'd0);
        chk({tag, "_done"}, 32'(cur_done), 32'd0);
        chk({tag, "_cut_in"}, cur_cut, 32'd0);
        chk({tag, "_sig"}, cur_sig,
            (which != 0) ? 32'(SEED_B) : 32'(SEED_A));
    endtask

    initial begin
        logic [7:0] gb;
        bit         seen;
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_golden = '0; a_mode = 0;
        b_start = 0; b_abort = 0; b_golden = '0;
        sel = 0;
        for (int i = 0; i < 32; i++) tbl[i] = 3'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_a_sig", 32'(a_sig), 32'(SEED_A));
        chk("rst_b_sig", 32'(b_sig), 32'(SEED_B));
        chk("rst_cut_in", 32'({a_cut_in, b_cut_in}), 32'd0);
        chk("rst_flags", 32'({a_busy, a_done, a_pass, b_busy, b_done, b_pass}), 32'd0);
        rst_n = 1'b1;

        run(0, 1'b0, "and");
        chk("and_sig_const", 32'(a_sig), 32'h1);
        a_golden = 4'h1;
        #1 chk("and_pass", 32'(a_pass), 32'd1);

        a_mode = 1'b1;
        run(0, 1'b0, "xor");
        chk("xor_sig_const", 32'(a_sig), 32'h6);
        a_golden = 4'h7;
        #1 chk("xor_pass", 32'(a_pass), 32'd0);
        chk("xor_done", 32'(a_done), 32'd1);

        abort_at2(0, "abort_a");
        run(0, 1'b0, "xor_rerun");
        chk("xor_rerun_sig", 32'(a_sig), 32'h6);

        for (int r = 0; r < 3; r++) begin
            if (r != 2)
                for (int i = 0; i < 32; i++) tbl[i] = 3'($urandom);
            run(1, r == 1, $sformatf("rnd%0d", r));
            b_golden = 8'(ref_sig(1));
            #1 chk($sformatf("rnd%0d_pass", r), 32'(b_pass), 32'd1);
            gb = b_golden ^ (8'd1 << $urandom_range(7, 0));
            b_golden = gb;
            #1 chk($sformatf("rnd%0d_flip", r), 32'(b_pass), 32'd0);
        end

        abort_at2(1, "abort_b");
        run(1, 1'b0, "rnd_after_abort");

        @(negedge clk);
        b_start = 1; b_abort = 1;
        @(negedge clk);
        b_start = 0; b_abort = 0;
        chk("both_busy", 32'(b_busy), 32'd0);
        chk("both_done", 32'(b_done), 32'd0);

        sel = 1;
        @(negedge clk);
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(b_busy), 32'd0);
        chk("arst_cut_in", 32'(b_cut_in), 32'd0);
        chk("arst_sig", 32'(b_sig), 32'(SEED_B));
        chk("arst_done", 32'(b_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (NPAT_B * (SET_B + 1) + 10) begin
            @(negedge clk);
            seen |= b_done | b_busy;
        end
        chk("arst_no_done", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
